// File: rtl/utils_pkg.sv
// Shared AXI channel types, register offsets, response codes and FSM state encodings
// for the reset controller.
package utils_pkg;

    typedef logic [3:0] axi_tid_t;

    typedef struct packed {
        axi_tid_t    awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
        axi_tid_t    arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        axi_tid_t    bid;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        axi_tid_t    rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
    } s_axi_miso_t;

    localparam logic [15:0] RST_ADDR_OFS = 16'h000;
    localparam logic [15:0] HOLD_OFS     = 16'h100;
    localparam logic [15:0] INFO_OFS     = 16'h104;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    typedef enum logic [1:0] {REG_RST_ADDR, REG_HOLD, REG_INFO, REG_NONE} reg_kind_e;

    function automatic reg_kind_e decode_addr(input logic [15:0] addr,
                                              input int unsigned num_harts);
        if (addr == HOLD_OFS) return REG_HOLD;
        if (addr == INFO_OFS) return REG_INFO;
        // Subtraction wraps below the base, so the range check also rejects it.
        if (addr[1:0] == 2'b00 && 32'((addr - RST_ADDR_OFS) >> 2) < num_harts) begin
            return REG_RST_ADDR;
        end
        return REG_NONE;
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rst_ctrl_mc_if.sv
// AXI slave request/response bundle for the reset controller.
interface rst_ctrl_mc_if;
    import utils_pkg::*;

    s_axi_mosi_t axi_mosi;
    s_axi_miso_t axi_miso;

    modport master (output axi_mosi, input axi_miso);
    modport slave  (input axi_mosi, output axi_miso);
endinterface

// File: rtl/rst_ctrl_regfile.sv
// Boot-vector and hold-mask storage with byte-strobe writes and a combinational read mux.
module rst_ctrl_regfile
    import utils_pkg::*;
#(
    parameter int unsigned           NUM_HARTS    = 2,
    parameter logic [31:0]           RST_ADDR_DEF = 32'h0,
    parameter logic [NUM_HARTS-1:0]  HOLD_DEF     = ~NUM_HARTS'(1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we_i,
    input  logic [15:0]                     waddr_i,
    input  logic [31:0]                     wdata_i,
    input  logic [3:0]                      wstrb_i,
    output logic                            werr_o,
    input  logic [15:0]                     raddr_i,
    output logic [31:0]                     rdata_o,
    output logic                            rerr_o,
    output logic [NUM_HARTS-1:0][31:0]      rst_addr_o,
    output logic [NUM_HARTS-1:0]            hold_o
);

    logic [NUM_HARTS-1:0][31:0] rst_addr_q, rst_addr_d;
    logic [NUM_HARTS-1:0]       hold_q, hold_d;
    reg_kind_e                  wkind, rkind;

`ifdef SIMULATION
    logic [NUM_HARTS-1:0][31:0] rst_loading;
`endif

    always_comb begin
        wkind      = decode_addr(waddr_i, NUM_HARTS);
        werr_o     = (wkind == REG_INFO) || (wkind == REG_NONE);
        rst_addr_d = rst_addr_q;
        hold_d     = hold_q;
        if (we_i) begin
            case (wkind)
                REG_RST_ADDR: begin
                    for (int i = 0; i < NUM_HARTS; i++) begin
                        if (waddr_i[15:2] == 14'(i)) begin
                            rst_addr_d[i] = strb_merge(rst_addr_q[i], wdata_i, wstrb_i);
                        end
                    end
                end
                REG_HOLD: begin
                    // Bits beyond NUM_HARTS have no storage, so their writes vanish.
                    for (int i = 0; i < NUM_HARTS; i++) begin
                        if (wstrb_i[i/8]) hold_d[i] = wdata_i[i];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rkind   = decode_addr(raddr_i, NUM_HARTS);
        rdata_o = '0;
        rerr_o  = 1'b0;
        case (rkind)
            REG_RST_ADDR: begin
                for (int i = 0; i < NUM_HARTS; i++) begin
                    if (raddr_i[15:2] == 14'(i)) rdata_o = rst_addr_q[i];
                end
            end
            REG_HOLD: rdata_o[NUM_HARTS-1:0] = hold_q;
            REG_INFO: rdata_o[7:0] = 8'(NUM_HARTS);
            default:  rerr_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
`ifdef SIMULATION
            rst_addr_q <= rst_loading;
`else
            rst_addr_q <= {NUM_HARTS{RST_ADDR_DEF}};
`endif
            hold_q     <= HOLD_DEF;
        end else begin
            rst_addr_q <= rst_addr_d;
            hold_q     <= hold_d;
        end
    end

    assign rst_addr_o = rst_addr_q;
    assign hold_o     = hold_q;

endmodule

// File: rtl/rst_ctrl_mc.sv
// Multi-hart reset controller: AXI-programmable boot vectors and hold mask driving
// registered per-hart active-low resets. Independent single-outstanding read/write FSMs.
module rst_ctrl_mc
    import utils_pkg::*;
#(
    parameter int unsigned           NUM_HARTS    = 2,
    parameter logic [31:0]           RST_ADDR_DEF = 32'h0,
    parameter logic [NUM_HARTS-1:0]  HOLD_DEF     = ~NUM_HARTS'(1)
) (
    input  logic                        clk,
    input  logic                        rst,
    rst_ctrl_mc_if.slave                axi,
    output logic [NUM_HARTS-1:0][31:0]  rst_addr_o,
    output logic [NUM_HARTS-1:0]        hart_rst_n_o
);

    s_axi_mosi_t mosi;
    s_axi_miso_t miso;

    w_state_e             w_state_q, w_state_d;
    r_state_e             r_state_q, r_state_d;
    logic [15:0]          awaddr_q, awaddr_d;
    axi_tid_t             awid_q, awid_d;
    axi_tid_t             arid_q, arid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [NUM_HARTS-1:0] hart_rst_n_q, hart_rst_n_d;

    logic                 rf_we, rf_werr, rf_rerr;
    logic [31:0]          rf_rdata;
    logic [NUM_HARTS-1:0] rf_hold;

    assign mosi = axi.axi_mosi;

    rst_ctrl_regfile #(
        .NUM_HARTS    (NUM_HARTS),
        .RST_ADDR_DEF (RST_ADDR_DEF),
        .HOLD_DEF     (HOLD_DEF)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (rf_we),
        .waddr_i    (awaddr_q),
        .wdata_i    (mosi.wdata),
        .wstrb_i    (mosi.wstrb),
        .werr_o     (rf_werr),
        .raddr_i    (mosi.araddr[15:0]),
        .rdata_o    (rf_rdata),
        .rerr_o     (rf_rerr),
        .rst_addr_o (rst_addr_o),
        .hold_o     (rf_hold)
    );

    always_comb begin
        miso         = '0;
        rf_we        = 1'b0;
        w_state_d    = w_state_q;
        r_state_d    = r_state_q;
        awaddr_d     = awaddr_q;
        awid_d       = awid_q;
        arid_d       = arid_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        hart_rst_n_d = ~rf_hold;

        unique case (w_state_q)
            W_IDLE: begin
                miso.awready = 1'b1;
                if (mosi.awvalid) begin
                    awaddr_d  = mosi.awaddr[15:0];
                    awid_d    = mosi.awid;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                miso.wready = 1'b1;
                if (mosi.wvalid) begin
                    rf_we     = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                miso.bvalid = 1'b1;
                miso.bid    = awid_q;
                miso.bresp  = rf_werr ? RESP_SLVERR : RESP_OKAY;
                if (mosi.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase

        unique case (r_state_q)
            R_IDLE: begin
                miso.arready = 1'b1;
                // Sampled from the pre-commit register state, so a same-cycle write is not seen.
                if (mosi.arvalid) begin
                    arid_d    = mosi.arid;
                    rdata_d   = rf_rdata;
                    rresp_d   = rf_rerr ? RESP_SLVERR : RESP_OKAY;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                miso.rvalid = 1'b1;
                miso.rlast  = 1'b1;
                miso.rid    = arid_q;
                miso.rdata  = rdata_q;
                miso.rresp  = rresp_q;
                if (mosi.rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state_q    <= W_IDLE;
            r_state_q    <= R_IDLE;
            awaddr_q     <= '0;
            awid_q       <= '0;
            arid_q       <= '0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            hart_rst_n_q <= '0;
        end else begin
            w_state_q    <= w_state_d;
            r_state_q    <= r_state_d;
            awaddr_q     <= awaddr_d;
            awid_q       <= awid_d;
            arid_q       <= arid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            hart_rst_n_q <= hart_rst_n_d;
        end
    end

    assign axi.axi_miso = miso;
    assign hart_rst_n_o = hart_rst_n_q;

    logic unused_mosi;
    assign unused_mosi = ^{mosi.awaddr[31:16], mosi.awlen, mosi.awsize, mosi.awburst,
                           mosi.wlast, mosi.araddr[31:16], mosi.arlen, mosi.arsize,
                           mosi.arburst};

endmodule

// File: tb/tb_rst_ctrl_mc.sv
// Directed bench for rst_ctrl_mc: reset, register access, strobes, errors, stalls,
// read/write overlap and reset during a write.
module tb_rst_ctrl_mc;
    import utils_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0][31:0]     rst_addr;
    logic [1:0]           hart_rst_n;
    s_axi_mosi_t          mosi;
    s_axi_miso_t          miso;
    int                   vecs = 0;
    int                   errs = 0;

    rst_ctrl_mc_if axi_if ();
    assign axi_if.axi_mosi = mosi;
    assign miso            = axi_if.axi_miso;

    rst_ctrl_mc #(.NUM_HARTS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .axi          (axi_if),
        .rst_addr_o   (rst_addr),
        .hart_rst_n_o (hart_rst_n)
    );

    always #5 clk = ~clk;

`ifdef SIMULATION
    initial dut.u_regfile.rst_loading = '0;
`endif

    function automatic bit sig(input int which);
        case (which)
            0:       return miso.awready;
            1:       return miso.wready;
            2:       return miso.bvalid;
            3:       return miso.arready;
            default: return miso.rvalid;
        endcase
    endfunction

    task automatic wait_sig(input int which, output bit to);
        int n = 0;
        to = 1'b0;
        while (!sig(which)) begin
            @(negedge clk);
            n++;
            if (n > 20) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic axi_write(input logic [15:0] a, input axi_tid_t id, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp, output axi_tid_t bid,
                             output bit to);
        bit t;
        to = 1'b0;
        mosi.awvalid = 1'b1; mosi.awaddr = {16'h0, a}; mosi.awid = id;
        wait_sig(0, t); to |= t;
        @(negedge clk);
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b1; mosi.wdata = d; mosi.wstrb = s;
        mosi.wlast = 1'b1;
        wait_sig(1, t); to |= t;
        @(negedge clk);
        mosi.wvalid = 1'b0; mosi.bready = 1'b1;
        wait_sig(2, t); to |= t;
        resp = miso.bresp; bid = miso.bid;
        @(negedge clk);
        mosi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] a, input axi_tid_t id, output logic [31:0] d,
                            output logic [1:0] resp, output axi_tid_t rid, output logic last,
                            output bit to);
        bit t;
        to = 1'b0;
        mosi.arvalid = 1'b1; mosi.araddr = {16'h0, a}; mosi.arid = id;
        wait_sig(3, t); to |= t;
        @(negedge clk);
        mosi.arvalid = 1'b0; mosi.rready = 1'b1;
        wait_sig(4, t); to |= t;
        d = miso.rdata; resp = miso.rresp; rid = miso.rid; last = miso.rlast;
        @(negedge clk);
        mosi.rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; mosi = '0;
        repeat (3) @(negedge clk);
        vecs++; if (hart_rst_n !== 2'b00) begin errs++; $display("FAIL reset_hart: got %b want 00", hart_rst_n); end
        vecs++; if (rst_addr !== '0) begin errs++; $display("FAIL reset_addr: got %h want 0", rst_addr); end
        vecs++; if (miso.bvalid !== 1'b0 || miso.rvalid !== 1'b0) begin errs++; $display("FAIL reset_valid: got b%b r%b want 0 0", miso.bvalid, miso.rvalid); end
        rst = 1'b1;
        vecs++; if (hart_rst_n !== 2'b00) begin errs++; $display("FAIL release_pre_edge: got %b want 00", hart_rst_n); end
        @(negedge clk);
        vecs++; if (hart_rst_n !== 2'b01) begin errs++; $display("FAIL release_hart: got %b want 01", hart_rst_n); end
        vecs++; if (miso.awready !== 1'b1 || miso.arready !== 1'b1) begin errs++; $display("FAIL idle_ready: got aw%b ar%b want 1 1", miso.awready, miso.arready); end
    endtask

    task automatic test_write_read();
        logic [1:0] resp; axi_tid_t id; logic [31:0] d; logic last; bit to;
        axi_write(16'h004, 4'd3, 32'h8000_0000, 4'hF, resp, id, to);
        vecs++; if (to) begin errs++; $display("FAIL wr_timeout: got timeout want response"); end
        vecs++; if (resp !== RESP_OKAY || id !== 4'd3) begin errs++; $display("FAIL wr_resp: got resp %b bid %0d want 00 3", resp, id); end
        vecs++; if (rst_addr[1] !== 32'h8000_0000 || rst_addr[0] !== 32'h0) begin errs++; $display("FAIL wr_vec: got %h want 80000000_00000000", rst_addr); end
        axi_read(16'h004, 4'd5, d, resp, id, last, to);
        vecs++; if (to) begin errs++; $display("FAIL rd_timeout: got timeout want response"); end
        vecs++; if (d !== 32'h8000_0000 || resp !== RESP_OKAY) begin errs++; $display("FAIL rd_data: got %h/%b want 80000000/00", d, resp); end
        vecs++; if (id !== 4'd5 || last !== 1'b1) begin errs++; $display("FAIL rd_id: got rid %0d rlast %b want 5 1", id, last); end
    endtask

    task automatic test_hold();
        logic [1:0] resp; axi_tid_t id; logic [31:0] d; logic last; bit to;
        axi_write(16'h100, 4'd1, 32'h0, 4'hF, resp, id, to);
        vecs++; if (to || resp !== RESP_OKAY) begin errs++; $display("FAIL hold_clr_resp: got to%b %b want 0 00", to, resp); end
        vecs++; if (hart_rst_n !== 2'b11) begin errs++; $display("FAIL hold_clr_hart: got %b want 11", hart_rst_n); end
        axi_write(16'h100, 4'd2, 32'hFFFF_FFFE, 4'hF, resp, id, to);
        vecs++; if (hart_rst_n !== 2'b01) begin errs++; $display("FAIL hold_set_hart: got %b want 01", hart_rst_n); end
        axi_read(16'h100, 4'd0, d, resp, id, last, to);
        vecs++; if (to || d !== 32'h2 || resp !== RESP_OKAY) begin errs++; $display("FAIL hold_read: got %h/%b want 00000002/00", d, resp); end
    endtask

    task automatic test_strobes();
        logic [1:0] resp; axi_tid_t id; logic [31:0] d; logic last; bit to;
        axi_write(16'h000, 4'd0, 32'h1000_0000, 4'hF, resp, id, to);
        axi_write(16'h000, 4'd0, 32'hFFFF_FFAA, 4'h1, resp, id, to);
        vecs++; if (rst_addr[0] !== 32'h1000_00AA) begin errs++; $display("FAIL strb_low: got %h want 100000aa", rst_addr[0]); end
        axi_read(16'h000, 4'd4, d, resp, id, last, to);
        vecs++; if (to || d !== 32'h1000_00AA) begin errs++; $display("FAIL strb_read: got %h want 100000aa", d); end
        axi_write(16'h004, 4'd0, 32'h00BB_CC00, 4'h6, resp, id, to);
        vecs++; if (rst_addr[1] !== 32'h80BB_CC00) begin errs++; $display("FAIL strb_mid: got %h want 80bbcc00", rst_addr[1]); end
    endtask

    task automatic test_errors();
        logic [1:0] resp; axi_tid_t id; logic [31:0] d; logic last; bit to;
        axi_read(16'h200, 4'd6, d, resp, id, last, to);
        vecs++; if (to || resp !== RESP_SLVERR || d !== 32'h0) begin errs++; $display("FAIL rd_unmapped: got %h/%b want 00000000/10", d, resp); end
        axi_write(16'h104, 4'd7, 32'hFF, 4'hF, resp, id, to);
        vecs++; if (to || resp !== RESP_SLVERR || id !== 4'd7) begin errs++; $display("FAIL wr_info: got %b bid %0d want 10 7", resp, id); end
        axi_read(16'h104, 4'd1, d, resp, id, last, to);
        vecs++; if (to || resp !== RESP_OKAY || d !== 32'h2) begin errs++; $display("FAIL rd_info: got %h/%b want 00000002/00", d, resp); end
        axi_read(16'h008, 4'd1, d, resp, id, last, to);
        vecs++; if (to || resp !== RESP_SLVERR || d !== 32'h0) begin errs++; $display("FAIL rd_past_harts: got %h/%b want 00000000/10", d, resp); end
        axi_write(16'h008, 4'd1, 32'h5555_5555, 4'hF, resp, id, to);
        vecs++; if (resp !== RESP_SLVERR || rst_addr[0] !== 32'h1000_00AA || rst_addr[1] !== 32'h80BB_CC00) begin errs++; $display("FAIL wr_past_harts: got %b %h want 10 80bbcc00_100000aa", resp, rst_addr); end
    endtask

    task automatic test_bready_stall();
        logic [1:0] resp; axi_tid_t id; logic [31:0] d; logic last; bit to;
        mosi.awvalid = 1'b1; mosi.awaddr = 32'h0; mosi.awid = 4'd7;
        wait_sig(0, to);
        @(negedge clk);
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b1; mosi.wdata = 32'h2000_0000; mosi.wstrb = 4'hF;
        wait_sig(1, to);
        @(negedge clk);
        mosi.wvalid = 1'b0; mosi.bready = 1'b0;
        vecs++; if (miso.bvalid !== 1'b1 || miso.awready !== 1'b0) begin errs++; $display("FAIL stall_0: got b%b aw%b want 1 0", miso.bvalid, miso.awready); end
        axi_read(16'h004, 4'd2, d, resp, id, last, to);
        vecs++; if (to || d !== 32'h80BB_CC00 || id !== 4'd2) begin errs++; $display("FAIL stall_read: got %h rid %0d want 80bbcc00 2", d, id); end
        for (int k = 0; k < 3; k++) begin
            vecs++; if (miso.bvalid !== 1'b1 || miso.awready !== 1'b0) begin errs++; $display("FAIL stall_%0d: got b%b aw%b want 1 0", k + 1, miso.bvalid, miso.awready); end
            @(negedge clk);
        end
        mosi.bready = 1'b1;
        vecs++; if (miso.bid !== 4'd7 || miso.bresp !== RESP_OKAY) begin errs++; $display("FAIL stall_resp: got bid %0d %b want 7 00", miso.bid, miso.bresp); end
        @(negedge clk);
        mosi.bready = 1'b0;
        vecs++; if (miso.bvalid !== 1'b0 || rst_addr[0] !== 32'h2000_0000) begin errs++; $display("FAIL stall_done: got b%b %h want 0 20000000", miso.bvalid, rst_addr[0]); end
    endtask

    task automatic test_back_to_back();
        bit to;
        mosi.awvalid = 1'b1; mosi.awaddr = 32'h4; mosi.awid = 4'd1;
        wait_sig(0, to);
        @(negedge clk);
        mosi.awvalid = 1'b0; mosi.wvalid = 1'b1; mosi.wdata = 32'h1234_5678; mosi.wstrb = 4'hF;
        mosi.arvalid = 1'b1; mosi.araddr = 32'h4; mosi.arid = 4'd9;
        vecs++; if (miso.wready !== 1'b1 || miso.arready !== 1'b1) begin errs++; $display("FAIL overlap_ready: got w%b ar%b want 1 1", miso.wready, miso.arready); end
        @(negedge clk);
        mosi.wvalid = 1'b0; mosi.arvalid = 1'b0; mosi.rready = 1'b1; mosi.bready = 1'b1;
        vecs++; if (miso.rvalid !== 1'b1 || miso.rdata !== 32'h80BB_CC00 || miso.bvalid !== 1'b1) begin errs++; $display("FAIL overlap_old: got r%b %h b%b want 1 80bbcc00 1", miso.rvalid, miso.rdata, miso.bvalid); end
        @(negedge clk);
        mosi.rready = 1'b0; mosi.bready = 1'b0;
        vecs++; if (rst_addr[1] !== 32'h1234_5678) begin errs++; $display("FAIL overlap_new: got %h want 12345678", rst_addr[1]); end
    endtask

    task automatic test_reset_mid_write();
        bit to;
        mosi.awvalid = 1'b1; mosi.awaddr = 32'h0; mosi.awid = 4'd2;
        wait_sig(0, to);
        @(negedge clk);
        mosi.awvalid = 1'b0;
        vecs++; if (miso.wready !== 1'b1) begin errs++; $display("FAIL mid_in_wdata: got wready %b want 1", miso.wready); end
        rst = 1'b0; mosi.wvalid = 1'b1; mosi.wdata = 32'hDEAD_BEEF; mosi.wstrb = 4'hF;
        @(negedge clk);
        mosi.wvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        vecs++; if (hart_rst_n !== 2'b00) begin errs++; $display("FAIL mid_hart_rst: got %b want 00", hart_rst_n); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vecs++; if (miso.bvalid !== 1'b0) begin errs++; $display("FAIL mid_no_b_%0d: got bvalid %b want 0", k, miso.bvalid); end
        end
        vecs++; if (rst_addr !== '0 || hart_rst_n !== 2'b01) begin errs++; $display("FAIL mid_state: got %h %b want 0 01", rst_addr, hart_rst_n); end
        vecs++; if (miso.awready !== 1'b1) begin errs++; $display("FAIL mid_idle: got awready %b want 1", miso.awready); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hold();
        test_strobes();
        test_errors();
        test_bready_stall();
        test_back_to_back();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
